// File: rtl/flit_pattern_checker_if.sv
// flit_pattern_checker_if
//   Groups the flit stream input and the checker's status/statistics outputs.
//   master : traffic source / observer (drives the flit stream)
//   slave  : the checker (drives status pulses and counters)
//   Signals:
//     in_valid     flit present this cycle
//     input1       flit low half  [N-1:0]
//     input2       flit high half [2N-1:N]
//     pkt_done     one-cycle pulse at packet close
//     pkt_ok       status of the last closed packet, held until next close
//     flit_err     one-cycle pulse per mismatching flit
//     trunc_err    one-cycle pulse with pkt_done when closed by timeout
//     pkt_count    packets closed (saturating)
//     err_count    mismatched flits (saturating)
//     flit_count   valid flits received (saturating)
//     cycle_count  cycles since reset release (saturating)
interface flit_pattern_checker_if #(
    parameter int N = 9
);
    logic         in_valid;
    logic [N-1:0] input1;
    logic [N-1:0] input2;
    logic         pkt_done;
    logic         pkt_ok;
    logic         flit_err;
    logic         trunc_err;
    logic [15:0]  pkt_count;
    logic [15:0]  err_count;
    logic [31:0]  flit_count;
    logic [31:0]  cycle_count;

    modport master (
        output in_valid, input1, input2,
        input  pkt_done, pkt_ok, flit_err, trunc_err,
        input  pkt_count, err_count, flit_count, cycle_count
    );

    modport slave (
        input  in_valid, input1, input2,
        output pkt_done, pkt_ok, flit_err, trunc_err,
        output pkt_count, err_count, flit_count, cycle_count
    );
endinterface

// File: rtl/flit_pattern_checker.sv
// flit_pattern_checker
//   Checks a packetized flit stream against a fixed 18-entry pattern table.
//   Each packet is PAYLOAD flits; flit k must equal E[k mod 18]. A packet is
//   closed either by its last flit or by TIMEOUT consecutive idle cycles
//   (truncation). Status pulses are registered; all counters saturate.
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    flit_pattern_checker_if.slave (flit input, status, counters)
module flit_pattern_checker #(
    parameter int PAYLOAD = 20,
    parameter int N       = 9,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    flit_pattern_checker_if.slave  bus
);
    localparam int W = 2 * N;

    typedef enum logic [1:0] {IDLE, RECV, CLOSE} state_t;

    state_t       state, state_nx;
    logic [7:0]   k, k_nx;            // flit index within packet
    logic [4:0]   pidx, pidx_nx;      // k mod 18, kept incrementally
    logic [7:0]   idle_t, idle_nx;    // consecutive idle cycles in RECV
    logic [7:0]   idle_inc;
    logic         perr, perr_nx;      // mismatch seen in current packet
    logic         close_nx;           // entering CLOSE this edge
    logic         trunc_nx;           // ... because of timeout
    logic         ok_nx;              // pkt_ok value for the closing packet

    logic [W-1:0] flit;
    logic [W-1:0] exp_flit;
    logic [4:0]   pidx_cur;
    logic         mismatch;

    logic         done_q, ok_q, ferr_q, trunc_q;
    logic [15:0]  pkt_cnt, err_cnt;
    logic [31:0]  flit_cnt, cyc_cnt;

    // Reference pattern, defined for an 18-bit flit. Other flit widths
    // see the same table zero-extended or truncated to 2N bits.
    function automatic logic [17:0] pattern18(input logic [4:0] i);
        logic [17:0] p;
        case (i)
            5'd0:    p = 18'h3FFF0;
            5'd1:    p = 18'h000FF;
            5'd2:    p = 18'h3F000;
            5'd3:    p = 18'h0FFFF;
            5'd4:    p = 18'h00003;
            5'd5:    p = 18'h3FFC0;
            5'd6:    p = 18'h003FF;
            5'd7:    p = 18'h3C000;
            5'd8:    p = 18'h3FFFF;
            5'd9:    p = 18'h0000F;
            5'd10:   p = 18'h3FF00;
            5'd11:   p = 18'h00FFF;
            5'd12:   p = 18'h30000;
            5'd13:   p = 18'h3FFFC;
            5'd14:   p = 18'h0003F;
            5'd15:   p = 18'h3FC00;
            5'd16:   p = 18'h03FFF;
            default: p = 18'h00000;
        endcase
        return p;
    endfunction

    // In IDLE and CLOSE an arriving flit is always index 0 of a new packet,
    // which is what lets back-to-back packets run without a gap.
    assign pidx_cur = (state == RECV) ? pidx : 5'd0;
    assign flit     = {bus.input2, bus.input1};
    assign exp_flit = W'(pattern18(pidx_cur));
    assign mismatch = bus.in_valid && (flit != exp_flit);
    assign idle_inc = idle_t + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            k      <= 8'd0;
            pidx   <= 5'd0;
            idle_t <= 8'd0;
            perr   <= 1'b0;
        end else begin
            state  <= state_nx;
            k      <= k_nx;
            pidx   <= pidx_nx;
            idle_t <= idle_nx;
            perr   <= perr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        pidx_nx  = pidx;
        idle_nx  = idle_t;
        perr_nx  = perr;
        close_nx = 1'b0;
        trunc_nx = 1'b0;
        ok_nx    = 1'b0;
        case (state)
            IDLE, CLOSE: begin
                state_nx = IDLE;
                k_nx     = 8'd0;
                pidx_nx  = 5'd0;
                idle_nx  = 8'd0;
                perr_nx  = 1'b0;
                if (bus.in_valid) begin
                    state_nx = RECV;
                    k_nx     = 8'd1;
                    pidx_nx  = 5'd1;
                    perr_nx  = mismatch;
                end
            end
            RECV: begin
                if (bus.in_valid) begin
                    idle_nx = 8'd0;
                    if (k == 8'(PAYLOAD - 1)) begin
                        // last flit: its own mismatch still counts
                        state_nx = CLOSE;
                        close_nx = 1'b1;
                        ok_nx    = !(perr || mismatch);
                        perr_nx  = 1'b0;
                        k_nx     = 8'd0;
                        pidx_nx  = 5'd0;
                    end else begin
                        perr_nx = perr || mismatch;
                        k_nx    = k + 8'd1;
                        pidx_nx = (pidx == 5'd17) ? 5'd0 : pidx + 5'd1;
                    end
                end else begin
                    idle_nx = idle_inc;
                    if (idle_inc == 8'(TIMEOUT)) begin
                        state_nx = CLOSE;
                        close_nx = 1'b1;
                        trunc_nx = 1'b1;
                        ok_nx    = 1'b0;
                        perr_nx  = 1'b0;
                        k_nx     = 8'd0;
                        pidx_nx  = 5'd0;
                        idle_nx  = 8'd0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                k_nx     = 8'd0;
                pidx_nx  = 5'd0;
                idle_nx  = 8'd0;
                perr_nx  = 1'b0;
            end
        endcase
    end

    // Status pulses and counters are registered off the same edge that
    // moves the FSM into CLOSE, so pkt_done lines up with the CLOSE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            ferr_q   <= 1'b0;
            trunc_q  <= 1'b0;
            pkt_cnt  <= 16'd0;
            err_cnt  <= 16'd0;
            flit_cnt <= 32'd0;
            cyc_cnt  <= 32'd0;
        end else begin
            done_q  <= close_nx;
            trunc_q <= trunc_nx;
            ferr_q  <= mismatch;
            if (close_nx)
                ok_q <= ok_nx;
            if (close_nx && (pkt_cnt != 16'hFFFF))
                pkt_cnt <= pkt_cnt + 16'd1;
            if (mismatch && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
            if (bus.in_valid && (flit_cnt != 32'hFFFF_FFFF))
                flit_cnt <= flit_cnt + 32'd1;
            if (cyc_cnt != 32'hFFFF_FFFF)
                cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    assign bus.pkt_done    = done_q;
    assign bus.pkt_ok      = ok_q;
    assign bus.flit_err    = ferr_q;
    assign bus.trunc_err   = trunc_q;
    assign bus.pkt_count   = pkt_cnt;
    assign bus.err_count   = err_cnt;
    assign bus.flit_count  = flit_cnt;
    assign bus.cycle_count = cyc_cnt;

endmodule

// File: tb/tb_flit_pattern_checker.sv
// tb_flit_pattern_checker
//   Directed scenarios driving flit_pattern_checker; expected packet closes
//   and flit errors are queued as stimulus is issued and checked by an
//   independent monitor on the falling edge.
module tb_flit_pattern_checker;
    localparam int PAYLOAD = 20;
    localparam int N       = 9;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flit_pattern_checker_if #(.N(N)) bus ();

    flit_pattern_checker #(
        .PAYLOAD(PAYLOAD),
        .N      (N),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic ok;
        logic trunc;
        int   cyc;
    } done_t;

    typedef struct {
        int cnt;
        int cyc;
    } ferr_t;

    done_t       done_q[$];
    ferr_t       ferr_q[$];
    logic [17:0] etab [18];
    int          errors = 0;
    int          checks = 0;
    int          ncyc;
    int          exp_err;
    int          last_done_cc;

    // bench's own count of rising edges since reset release
    always @(posedge clk or negedge rst_n)
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // monitor
    always @(negedge clk) begin : mon
        done_t d;
        ferr_t f;
        if (rst_n) begin
            if (bus.pkt_done) begin
                last_done_cc = int'(bus.cycle_count);
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pkt_done at cycle %0d", ncyc);
                end else begin
                    d = done_q.pop_front();
                    chk("pkt_ok", 32'(bus.pkt_ok), 32'(d.ok));
                    chk("trunc_err", 32'(bus.trunc_err), 32'(d.trunc));
                    chk("done_cycle", ncyc, d.cyc);
                end
            end else if (bus.trunc_err) begin
                checks++;
                errors++;
                $display("FAIL trunc_without_done at cycle %0d", ncyc);
            end
            if (bus.flit_err) begin
                if (ferr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit_err at cycle %0d", ncyc);
                end else begin
                    f = ferr_q.pop_front();
                    chk("err_count_at_flit_err", 32'(bus.err_count), f.cnt);
                    chk("flit_err_cycle", ncyc, f.cyc);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.input1 = '0;
        bus.input2 = '0;
        #1;
        chk("rst_pkt_done", 32'(bus.pkt_done), 0);
        chk("rst_pkt_ok", 32'(bus.pkt_ok), 0);
        chk("rst_flit_err", 32'(bus.flit_err), 0);
        chk("rst_trunc_err", 32'(bus.trunc_err), 0);
        chk("rst_pkt_count", 32'(bus.pkt_count), 0);
        chk("rst_err_count", 32'(bus.err_count), 0);
        chk("rst_flit_count", bus.flit_count, 0);
        chk("rst_cycle_count", bus.cycle_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_err = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    // flit driven now is sampled on edge ncyc+1; its registered response
    // (flit_err / pkt_done) is visible while ncyc == that edge count
    task automatic send_pkt(input int nflits, input int bad_idx, input bit trunc);
        logic [17:0] f;
        bit bad = 0;
        for (int i = 0; i < nflits; i++) begin
            f = (i == bad_idx) ? 18'h00000 : etab[i % 18];
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            {bus.input2, bus.input1} = f;
            if (f != etab[i % 18]) begin
                bad = 1;
                exp_err++;
                ferr_q.push_back('{cnt: exp_err, cyc: ncyc + 1});
            end
        end
        if (nflits == PAYLOAD)
            done_q.push_back('{ok: !bad, trunc: 1'b0, cyc: ncyc + 1});
        if (trunc) begin
            idle(TIMEOUT);
            done_q.push_back('{ok: 1'b0, trunc: 1'b1, cyc: ncyc + 1});
        end
    endtask

    task automatic drain(input string name);
        int i;
        idle(TIMEOUT + 5);
        for (i = 0; i < 50; i++) begin
            if (done_q.size() == 0 && ferr_q.size() == 0) break;
            @(posedge clk);
        end
        checks++;
        if (done_q.size() != 0 || ferr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d done/%0d ferr outstanding expected 0/0",
                     name, done_q.size(), ferr_q.size());
            done_q.delete();
            ferr_q.delete();
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        etab = '{18'h3FFF0, 18'h000FF, 18'h3F000, 18'h0FFFF, 18'h00003, 18'h3FFC0,
                 18'h003FF, 18'h3C000, 18'h3FFFF, 18'h0000F, 18'h3FF00, 18'h00FFF,
                 18'h30000, 18'h3FFFC, 18'h0003F, 18'h3FC00, 18'h03FFF, 18'h00000};
        bus.in_valid = 1'b0;
        bus.input1 = '0;
        bus.input2 = '0;
        exp_err = 0;
        last_done_cc = 0;

        // normal traffic / utilization
        do_reset();
        idle(8);
        for (int p = 0; p < 10; p++) begin
            send_pkt(PAYLOAD, -1, 0);
            idle(7);
        end
        drain("normal");
        chk("normal_pkt_count", 32'(bus.pkt_count), 10);
        chk("normal_err_count", 32'(bus.err_count), 0);
        chk("normal_flit_count", bus.flit_count, 200);
        chk("normal_pkt_ok_held", 32'(bus.pkt_ok), 1);
        chk("util_cycles_ge_270", 32'(last_done_cc >= 270), 1);
        chk("cycle_count_track", bus.cycle_count, ncyc);

        // corrupted flit in the middle packet
        do_reset();
        send_pkt(PAYLOAD, -1, 0);
        idle(7);
        send_pkt(PAYLOAD, 5, 0);
        idle(7);
        send_pkt(PAYLOAD, -1, 0);
        drain("corrupt");
        chk("corrupt_err_count", 32'(bus.err_count), 1);
        chk("corrupt_pkt_count", 32'(bus.pkt_count), 3);
        chk("corrupt_flit_count", bus.flit_count, 60);

        // truncation by timeout
        do_reset();
        send_pkt(12, -1, 1);
        drain("trunc");
        chk("trunc_pkt_count", 32'(bus.pkt_count), 1);
        chk("trunc_pkt_ok_held", 32'(bus.pkt_ok), 0);
        chk("trunc_flit_count", bus.flit_count, 12);

        // back-to-back packets
        do_reset();
        send_pkt(PAYLOAD, -1, 0);
        send_pkt(PAYLOAD, -1, 0);
        drain("b2b");
        chk("b2b_pkt_count", 32'(bus.pkt_count), 2);
        chk("b2b_flit_count", bus.flit_count, 40);
        chk("b2b_err_count", 32'(bus.err_count), 0);

        // reset mid-packet, then a clean packet
        do_reset();
        send_pkt(10, -1, 0);
        do_reset();
        send_pkt(PAYLOAD, -1, 0);
        drain("midrst");
        chk("midrst_pkt_count", 32'(bus.pkt_count), 1);
        chk("midrst_flit_count", bus.flit_count, 20);
        chk("midrst_pkt_ok", 32'(bus.pkt_ok), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/flit_pattern_checker.md
FLIT_PATTERN_CHECKER -- requirements
Module: flit_pattern_checker

Interface
REQ-001 SHALL have parameter PAYLOAD, default 20, meaning flits per packet (2..255).
REQ-002 SHALL have parameter N, default 9, meaning width of each flit half; flit width = 2N.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum consecutive idle cycles allowed inside a packet (1..255).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  flit present this cycle.
REQ-007 input1  input  N  flit low half, bits [N-1:0].
REQ-008 input2  input  N  flit high half, bits [2N-1:N].
REQ-009 pkt_done  output  1  one-cycle pulse at packet close.
REQ-010 pkt_ok  output  1  status of the last closed packet; valid while pkt_done is high and held until the next close.
REQ-011 flit_err  output  1  one-cycle pulse, registered, for each flit mismatching the expected pattern.
REQ-012 trunc_err  output  1  one-cycle pulse, coincident with pkt_done, when a packet is closed by timeout.
REQ-013 pkt_count  output  16  packets closed, saturating at 16'hFFFF.
REQ-014 err_count  output  16  mismatched flits, saturating.
REQ-015 flit_count  output  32  valid flits received, saturating.
REQ-016 cycle_count  output  32  cycles since reset release, saturating; flit_count/cycle_count gives link utilization.

Function
REQ-017 SHALL form flit = {input2, input1} (2N bits) on every cycle where in_valid is high.
REQ-018 SHALL compare each flit against expected table E[k mod 18], where k is the 0-based flit index within the packet.
REQ-019 E for N=9, in hex, index 0..17: 3FFF0, 000FF, 3F000, 0FFFF, 00003, 3FFC0, 003FF, 3C000, 3FFFF, 0000F, 3FF00, 00FFF, 30000, 3FFFC, 0003F, 3FC00, 03FFF, 00000.
REQ-020 SHALL run an FSM with states IDLE, RECV and CLOSE.
REQ-021 IDLE: in_valid high -> check the flit with k=0, set k=1, go to RECV; otherwise stay in IDLE with the idle timer held at 0.
REQ-022 RECV: in_valid high -> check the flit at k, k+1, idle timer reset to 0; on the PAYLOAD-th flit (k=PAYLOAD-1) -> go to CLOSE.
REQ-023 RECV: in_valid low -> idle timer +1; when the timer reaches TIMEOUT -> go to CLOSE with the truncation flag set.
REQ-024 CLOSE lasts exactly one cycle and SHALL do all of the following:
- assert pkt_done;
- set pkt_ok = (no mismatch in this packet AND not truncated);
- pulse trunc_err if truncated;
- increment pkt_count;
- clear k and the per-packet error flag;
- go to IDLE.
REQ-025 A flit with in_valid high during CLOSE SHALL be accepted as k=0 of the next packet, and the FSM SHALL go to RECV (back-to-back packets lose no flits).
REQ-026 flit_err SHALL assert in the cycle after the mismatching flit is sampled; err_count SHALL update in that same cycle.
REQ-027 Latency: pkt_done SHALL assert in the cycle after the last flit is sampled, or the cycle after the timeout is reached.
REQ-028 All counters SHALL saturate and SHALL NOT wrap; k SHALL stay 8 bits wide.

Reset
REQ-029 rst_n low SHALL immediately drive the FSM to IDLE and clear k, the idle timer, all counters, pkt_done, pkt_ok, flit_err and trunc_err.
REQ-030 Reset asserted mid-packet SHALL discard the partial packet without pulsing pkt_done; counting SHALL resume on the first clk edge after release.

Verification
REQ-031 Normal packet: 20 flits following E[k mod 18], then 7 idle cycles, repeated 10 times -> pkt_done x10, pkt_ok=1, err_count=0, pkt_count=10, flit_count=200.
REQ-032 Corrupted flit: in packet 1, flit 5 = 00000 instead of 3FFC0 -> flit_err pulses once, err_count=1, that packet's pkt_ok=0, the next packet's pkt_ok=1.
REQ-033 Truncation: 12 flits then in_valid low for 15 cycles -> pkt_done with trunc_err=1, pkt_ok=0, pkt_count=1.
REQ-034 Back-to-back: two 20-flit packets with no idle gap -> 2 pkt_done pulses, both pkt_ok=1, flit_count=40.
REQ-035 Reset mid-packet: rst_n low after flit 10, then a full correct packet -> pkt_count=1, pkt_ok=1, flit_count=20.
REQ-036 Utilization: 10 packets with 7-cycle gaps -> flit_count=200, cycle_count no less than 270 at the last pkt_done.
